test_monitor: RTL
=================

// Module: test_monitor
// PURPOSE
// - Memory-mapped simulation/FPGA test-status device on the CPU mmio bus; software reports pass/fail instead of
//   the bench polling register-file values at fixed cycle counts.
// - Provides free-running cycle counter, NUM_CHECKPOINTS scratch checkpoint registers and a timeout watchdog.
// - AXI4-Lite slave. Bench waits on done, then reads pass/code; no hierarchical peeking into cpu internals.
// PARAMETERS
// - ADDR_WIDTH       12      byte-address bits decoded (upper bits ignored)
// - NUM_CHECKPOINTS  4       checkpoint registers, 1..16
// - TIMEOUT_CYCLES   100000  cycles after reset before forced fail; 0 disables watchdog
// PORTS
// - clk      in   1   clock
// - rst      in   1   synchronous reset, active-high
// - awvalid/awready  in/out  1   write-address handshake;  awaddr  in  ADDR_WIDTH
// - wvalid/wready    in/out  1   write-data handshake;  wdata  in  32;  wstrb  in  4
// - bvalid/bready    out/in  1   write-response handshake;  bresp  out  2
// - arvalid/arready  in/out  1   read-address handshake;  araddr  in  ADDR_WIDTH
// - rvalid/rready    out/in  1   read-data handshake;  rdata  out  32;  rresp  out  2
// - done     out  1   sticky: test finished (software report or timeout)
// - pass     out  1   valid when done; 1 = code 0 reported by software
// - code     out  31  reported fail code; all-ones on timeout
// - timeout  out  1   sticky: watchdog expired before software report
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high on clk/rst.
// - Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, done/pass/timeout 0, code 0,
//   cycle counter 0, checkpoints 0. Reset mid-transaction abandons it; no response is issued.
// - Register map (word offsets, addr[1:0] ignored):
//   0x000 TOHOST  W: bit0=1 ends test, code=wdata[31:1]; pass=(code==0). R: {code,done}
//   0x004 CYCLE   RO 32-bit cycle count since reset, saturates at 32'hFFFF_FFFF
//   0x008 STATUS  RO {29'b0, timeout, pass, done}
//   0x040+4*i CHECKPOINT[i]  RW, byte strobes honoured, i < NUM_CHECKPOINTS
// - Write FSM W_IDLE -> W_RESP -> W_IDLE:
//   W_IDLE: awready=wready=1 only in the cycle both awvalid and wvalid are high; the register update
//   happens in that cycle; next state W_RESP.
//   W_RESP: bvalid=1, bresp held stable until bready; returns to W_IDLE the cycle after bready.
//   No new write is accepted while bvalid=1.
// - Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1 while rvalid=0.
//   R_DATA: rdata/rresp registered one cycle after the handshake; rvalid held until rready.
// - Reads and writes are independent and may complete in the same cycle. A read of a register written
//   in the same cycle returns the old value.
// - Responses: OKAY=2'b00; SLVERR=2'b10 for unmapped address, write to CYCLE/STATUS, or TOHOST write
//   with wstrb!=4'hF. SLVERR writes have no effect; SLVERR reads return rdata=0.
// - done, pass, code, timeout are sticky until rst. TOHOST writes after done are ignored but respond OKAY.
//   TOHOST with bit0=0 is a no-op (OKAY).
// - Watchdog: if TIMEOUT_CYCLES!=0 and done=0 when cycle==TIMEOUT_CYCLES-1, then next cycle
//   done=1, timeout=1, pass=0, code='1.
// - Simultaneous accepted TOHOST write and watchdog expiry in the same cycle: the software report wins
//   and timeout stays 0.
// - Outputs are registered; done rises one cycle after the TOHOST write handshake.
// STRUCTURE
// - Package test_pkg: register offsets (TOHOST, CYCLE, STATUS, CHECKPOINT_BASE), resp_t enum
//   (OKAY, SLVERR), wstate_t and rstate_t FSM enums.
// - Single module. No sub-module; the address decode is a function shared by the read and write paths.
// - The AXI axi interface wraps onto these ports in the bench via a thin modport adapter, outside this file.
// TESTING
// - Write TOHOST 0x0000_0001, strb F -> bresp OKAY; done=1 and pass=1 one cycle after the handshake; STATUS reads 0x3.
// - Write TOHOST 0x0000_0007 -> done=1, pass=0, code=3; a later write of 0x1 leaves code=3 and returns OKAY.
// - TIMEOUT_CYCLES=50, no writes -> done=timeout=1, code=all-ones after cycle 50.
//   Same run with a TOHOST write accepted at cycle 49 -> timeout=0.
// - CHECKPOINT[2] write 0xDEAD_BEEF strb F, then strb 4'b0001 data 0x55 -> read returns 0xDEAD_BE55.
// - Read 0x100 (unmapped), write CYCLE, TOHOST with strb 4'h3 -> all SLVERR; rdata=0; state unchanged.
// - Hold bready/rready low 5 cycles -> bvalid/rvalid and their data stay stable; AW/W not accepted
//   meanwhile. Assert rst mid-response -> all valids 0 next cycle.

Source files
------------

// File: rtl/test_pkg.sv
// rtl/test_pkg.sv - shared definitions for the test_monitor status device
// Purpose: register offsets, response codes, FSM state types and decode result type.
// Ports: none (package).
package test_pkg;

  localparam logic [31:0] TOHOST_OFS      = 32'h000;
  localparam logic [31:0] CYCLE_OFS       = 32'h004;
  localparam logic [31:0] STATUS_OFS      = 32'h008;
  localparam logic [31:0] CHECKPOINT_BASE = 32'h040;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TOHOST,
    SEL_CYCLE,
    SEL_STATUS,
    SEL_CKPT
  } sel_t;

  typedef struct packed {
    sel_t       sel;
    logic [3:0] idx;
  } dec_t;

endpackage

// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - memory-mapped test status device (AXI4-Lite slave)
// Purpose: software reports pass/fail through TOHOST; also provides a saturating cycle
//          counter, scratch checkpoint registers and a timeout watchdog.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   aw*/w*/b*                     AXI4-Lite write address/data/response channels
//   ar*/r*                        AXI4-Lite read address/data channels
//   done, pass, code, timeout     sticky test result outputs
import test_pkg::*;

module test_monitor #(
  parameter int ADDR_WIDTH      = 12,
  parameter int NUM_CHECKPOINTS = 4,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  done,
  output logic                  pass,
  output logic [30:0]           code,
  output logic                  timeout
);

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'h0 : 32'(TIMEOUT_CYCLES - 1);

  // Shared by both channels; addr[1:0] are dropped so any byte address selects its word.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] w;
    dec_t        d;
    w     = 32'(a) & ~32'h3;
    d.sel = SEL_NONE;
    d.idx = '0;
    if (w == TOHOST_OFS)      d.sel = SEL_TOHOST;
    else if (w == CYCLE_OFS)  d.sel = SEL_CYCLE;
    else if (w == STATUS_OFS) d.sel = SEL_STATUS;
    else if (w >= CHECKPOINT_BASE && w < CHECKPOINT_BASE + 32'(4 * NUM_CHECKPOINTS)) begin
      d.sel = SEL_CKPT;
      d.idx = 4'((w - CHECKPOINT_BASE) >> 2);
    end
    return d;
  endfunction

  wstate_t     r_wstate, w_wstate_nxt;
  rstate_t     r_rstate, w_rstate_nxt;
  resp_t       r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic [31:0] r_cycle;
  logic        r_done, r_pass, r_timeout;
  logic [30:0] r_code;
  logic [31:0] r_ckpt [NUM_CHECKPOINTS];

  dec_t        w_wdec, w_rdec;
  logic        w_wr_fire, w_rd_fire;
  logic        w_wr_err, w_rd_err;
  logic [31:0] w_rd_val;
  logic        w_tohost_end, w_wd_expire, w_ck_we;

  assign w_wdec = decode(awaddr);
  assign w_rdec = decode(araddr);

  // Write FSM: AW and W are taken together in one cycle, never while a response is pending.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_fire    = 1'b0;
    awready      = 1'b0;
    wready       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (!rst && awvalid && wvalid) begin
          w_wr_fire    = 1'b1;
          awready      = 1'b1;
          wready       = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM: address accepted whenever no read data is outstanding.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_fire    = 1'b0;
    arready      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready = !rst;
        if (!rst && arvalid) begin
          w_rd_fire    = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // TOHOST needs a full-word strobe; CYCLE/STATUS are read-only.
  always_comb begin
    w_wr_err = 1'b1;
    case (w_wdec.sel)
      SEL_TOHOST: w_wr_err = (wstrb != 4'hF);
      SEL_CKPT:   w_wr_err = 1'b0;
      default:    w_wr_err = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    w_rd_err = 1'b0;
    case (w_rdec.sel)
      SEL_TOHOST: w_rd_val = {r_code, r_done};
      SEL_CYCLE:  w_rd_val = r_cycle;
      SEL_STATUS: w_rd_val = {29'b0, r_timeout, r_pass, r_done};
      SEL_CKPT: begin
        for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
          if (w_rdec.idx == 4'(i)) w_rd_val = r_ckpt[i];
        end
      end
      default: w_rd_err = 1'b1;
    endcase
  end

  assign w_ck_we      = w_wr_fire && !w_wr_err && (w_wdec.sel == SEL_CKPT);
  assign w_tohost_end = w_wr_fire && !w_wr_err && (w_wdec.sel == SEL_TOHOST) && wdata[0] && !r_done;
  assign w_wd_expire  = (TIMEOUT_CYCLES != 0) && !r_done && (r_cycle == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bresp   <= OKAY;
      r_rresp   <= OKAY;
      r_rdata   <= '0;
      r_cycle   <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_code    <= '0;
      for (int i = 0; i < NUM_CHECKPOINTS; i++) r_ckpt[i] <= '0;
    end else begin
      if (r_cycle != 32'hFFFF_FFFF) r_cycle <= r_cycle + 32'd1;

      if (w_wr_fire) r_bresp <= w_wr_err ? SLVERR : OKAY;

      // A software report in the expiry cycle takes priority over the watchdog.
      if (w_tohost_end) begin
        r_done <= 1'b1;
        r_code <= wdata[31:1];
        r_pass <= (wdata[31:1] == 31'd0);
      end else if (w_wd_expire) begin
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
        r_pass    <= 1'b0;
        r_code    <= '1;
      end

      for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
        if (w_ck_we && w_wdec.idx == 4'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r_ckpt[i][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end

      if (w_rd_fire) begin
        r_rdata <= w_rd_err ? 32'h0 : w_rd_val;
        r_rresp <= w_rd_err ? SLVERR : OKAY;
      end
    end
  end

  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;
  assign rvalid  = (r_rstate == R_DATA);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign done    = r_done;
  assign pass    = r_pass;
  assign code    = r_code;
  assign timeout = r_timeout;

endmodule
